// File: rtl/fc_phase_sequencer.sv
// Start/done sequencer for the FC1 -> tanh -> FC2 -> softmax back end: drives the layer resets,
// the softmax enable and both weight-ROM addresses, with a watchdog on each completion-flag wait.
module fc_phase_sequencer #(
    parameter int IN_NODES = 120,
    parameter int FC1_OUT  = 84,
    parameter int FC2_OUT  = 10,
    parameter int ADDR_W   = 8,
    parameter int SETTLE   = 10,
    parameter int WDOG     = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              tanh_done_i,
    input  logic              smax_ack_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              fc1_rst_o,
    output logic              tanh_rst_o,
    output logic              fc2_rst_o,
    output logic              smax_en_o,
    output logic [ADDR_W-1:0] addr1_o,
    output logic [ADDR_W-1:0] addr2_o,
    output logic [2:0]        phase_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FC1  = 3'd1,
        S_TANH = 3'd2,
        S_FC2  = 3'd3,
        S_SMAX = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [9:0] FC1_LAST  = 10'(IN_NODES + SETTLE - 1);
    localparam logic [9:0] FC2_LAST  = 10'(FC1_OUT + SETTLE - 1);
    localparam logic [9:0] ROW1_LAST = 10'(IN_NODES - 1);
    localparam logic [9:0] ROW2_LAST = 10'(FC1_OUT - 1);
    localparam logic [9:0] WDOG_LAST = 10'(WDOG);

    generate
        if ((2 ** ADDR_W) <= IN_NODES || (2 ** ADDR_W) <= FC1_OUT || FC2_OUT < 1) begin : g_bad_params
            $error("fc_phase_sequencer: ADDR_W too narrow for the weight ROMs or FC2_OUT invalid");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [9:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              fc1_rst_q, fc1_rst_d;
    logic              tanh_rst_q, tanh_rst_d;
    logic              fc2_rst_q, fc2_rst_d;
    logic              smax_en_q, smax_en_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic [ADDR_W-1:0] addr2_q, addr2_d;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (start_i) begin
                state_d = S_FC1;
                err_d   = 1'b0;
            end
            S_FC1:  if (cnt_q == FC1_LAST) state_d = S_TANH;
            S_TANH: begin
                // a flag arriving on the watchdog cycle still counts as success
                if (tanh_done_i) state_d = S_FC2;
                else if (cnt_q == WDOG_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_FC2:  if (cnt_q == FC2_LAST) state_d = S_SMAX;
            S_SMAX: begin
                if (smax_ack_i) state_d = S_DONE;
                else if (cnt_q == WDOG_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_i) begin
            state_d = S_IDLE;
            err_d   = err_q;
        end

        cnt_d = (state_d != state_q) ? 10'd0 : 10'(cnt_q + 10'd1);

        // Outputs are registered from the next state; released resets stay low until IDLE.
        fc1_rst_d  = fc1_rst_q;
        tanh_rst_d = tanh_rst_q;
        fc2_rst_d  = fc2_rst_q;
        smax_en_d  = smax_en_q;
        addr1_d    = addr1_q;
        addr2_d    = addr2_q;
        case (state_d)
            S_IDLE: begin
                fc1_rst_d  = 1'b1;
                tanh_rst_d = 1'b1;
                fc2_rst_d  = 1'b1;
                smax_en_d  = 1'b0;
                addr1_d    = '1;
                addr2_d    = '1;
            end
            S_FC1: begin
                fc1_rst_d = 1'b0;
                addr1_d   = (cnt_d > ROW1_LAST) ? ADDR_W'(ROW1_LAST) : ADDR_W'(cnt_d);
            end
            S_TANH: tanh_rst_d = 1'b0;
            S_FC2: begin
                fc2_rst_d = 1'b0;
                addr2_d   = (cnt_d > ROW2_LAST) ? ADDR_W'(ROW2_LAST) : ADDR_W'(cnt_d);
            end
            S_SMAX:  smax_en_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 10'd0;
            err_q      <= 1'b0;
            fc1_rst_q  <= 1'b1;
            tanh_rst_q <= 1'b1;
            fc2_rst_q  <= 1'b1;
            smax_en_q  <= 1'b0;
            addr1_q    <= '1;
            addr2_q    <= '1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            phase_o    <= 3'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            fc1_rst_q  <= fc1_rst_d;
            tanh_rst_q <= tanh_rst_d;
            fc2_rst_q  <= fc2_rst_d;
            smax_en_q  <= smax_en_d;
            addr1_q    <= addr1_d;
            addr2_q    <= addr2_d;
            busy_o     <= (state_d != S_IDLE);
            done_o     <= (state_d == S_DONE);
            phase_o    <= state_d;
        end
    end

    assign err_o      = err_q;
    assign fc1_rst_o  = fc1_rst_q;
    assign tanh_rst_o = tanh_rst_q;
    assign fc2_rst_o  = fc2_rst_q;
    assign smax_en_o  = smax_en_q;
    assign addr1_o    = addr1_q;
    assign addr2_o    = addr2_q;

endmodule
